// File: rtl/cpu_bus_mapper.sv
// cpu_bus_mapper: CPU address decode to RAM/PPU/PRG RAM/PRG ROM with keyboard-driven serial pads at 0x4016/0x4017; ports: clk, reset_n, addr/we/re/data_in/data_out CPU bus, cpu_ram_*, prg_rom_*, prg_ram_*, ppu_* memory ports, kb_* scancode input, pad_state live buttons
module cpu_bus_mapper #(
  parameter int NUM_PADS   = 2,
  parameter int PRG_ROM_KB = 32,
  parameter int PRG_RAM_EN = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [15:0]             addr,
  input  logic                    we,
  input  logic                    re,
  input  logic [7:0]              data_in,
  output logic [7:0]              data_out,
  output logic [10:0]             cpu_ram_addr,
  output logic                    cpu_ram_we,
  input  logic [7:0]              cpu_ram_out,
  output logic [14:0]             prg_rom_addr,
  input  logic [7:0]              prg_rom_out,
  output logic [12:0]             prg_ram_addr,
  output logic                    prg_ram_we,
  input  logic [7:0]              prg_ram_out,
  output logic                    ppu_reg_cs_n,
  output logic [2:0]              ppu_reg_addr,
  output logic                    ppu_we,
  output logic [7:0]              ppu_data_out,
  input  logic [7:0]              ppu_data_in,
  input  logic [7:0]              kb_code,
  input  logic                    kb_valid,
  input  logic                    kb_make,
  output logic [8*NUM_PADS-1:0]   pad_state
);
  localparam logic [127:0] KEY_MAP = {64'h7071_5912_7573_6B74, 64'h1C1B_295A_4342_3B4B};
  logic       strobe;
  logic [1:0] ser;
  logic       ram_sel, ppu_sel, pram_sel, rom_sel;
  assign ram_sel  = addr[15:13] == 3'b000;
  assign ppu_sel  = addr[15:13] == 3'b001;
  assign pram_sel = PRG_RAM_EN != 0 && addr[15:13] == 3'b011;
  assign rom_sel  = addr[15];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) strobe <= 1'b0;
    else if (we && addr == 16'h4016) strobe <= data_in[0];
  end
  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    logic [7:0] pad_q, shift_q;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pad_q   <= '0;
        shift_q <= '0;
      end else begin
        for (int b = 0; b < 8; b++)
          if (kb_valid && kb_code == KEY_MAP[64*p + 8*b +: 8]) pad_q[b] <= kb_make;
        if (strobe) shift_q <= pad_q;
        else if (re && addr == {15'h200B, 1'(p)}) shift_q <= {shift_q[6:0], 1'b1};
      end
    end
    assign pad_state[8*p +: 8] = pad_q;
    assign ser[p] = strobe ? pad_q[7] : shift_q[7];
  end
  if (NUM_PADS == 1) begin : g_one
    assign ser[1] = 1'b0;
  end
  assign cpu_ram_addr = addr[10:0];
  assign cpu_ram_we   = we && ram_sel;
  assign ppu_reg_cs_n = !ppu_sel;
  assign ppu_reg_addr = addr[2:0];
  assign ppu_we       = we && ppu_sel;
  assign ppu_data_out = data_in;
  assign prg_ram_addr = addr[12:0];
  assign prg_ram_we   = we && pram_sel;
  assign prg_rom_addr = PRG_ROM_KB == 16 ? {1'b0, addr[13:0]} : addr[14:0];
  assign data_out = addr == 16'h4016 ? {7'h00, ser[0]} :
                    addr == 16'h4017 ? {7'h00, ser[1]} :
                    ram_sel          ? cpu_ram_out :
                    ppu_sel          ? ppu_data_in :
                    pram_sel         ? prg_ram_out :
                    rom_sel          ? prg_rom_out : 8'h00;
endmodule

// File: tb/tb_cpu_bus_mapper.sv
// tb_cpu_bus_mapper: directed bench with a behavioural pad/decode model checked every cycle
module tb_cpu_bus_mapper;
  logic clk = 1'b0, reset_n = 1'b1, we = 1'b0, re = 1'b0, kb_valid = 1'b0, kb_make = 1'b0;
  logic [15:0] addr = 16'h5000;
  logic [7:0] data_in = 8'h00, kb_code = 8'h00;
  logic [7:0] cpu_ram_out = 8'hA1, ppu_data_in = 8'hB2, prg_ram_out = 8'hC3, prg_rom_out = 8'hD4;
  logic [7:0] data_out, ppu_data_out, data_out2, ppu_data_out2;
  logic [10:0] cpu_ram_addr, cpu_ram_addr2;
  logic [14:0] prg_rom_addr, prg_rom_addr2;
  logic [12:0] prg_ram_addr, prg_ram_addr2;
  logic [2:0] ppu_reg_addr, ppu_reg_addr2;
  logic cpu_ram_we, prg_ram_we, ppu_reg_cs_n, ppu_we;
  logic cpu_ram_we2, prg_ram_we2, ppu_reg_cs_n2, ppu_we2;
  logic [15:0] pad_state;
  logic [7:0] pad_state2;
  int checks = 0, failures = 0;
  bit go = 0;
  always #5 clk = ~clk;
  cpu_bus_mapper dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .we(we), .re(re), .data_in(data_in), .data_out(data_out),
    .cpu_ram_addr(cpu_ram_addr), .cpu_ram_we(cpu_ram_we), .cpu_ram_out(cpu_ram_out),
    .prg_rom_addr(prg_rom_addr), .prg_rom_out(prg_rom_out),
    .prg_ram_addr(prg_ram_addr), .prg_ram_we(prg_ram_we), .prg_ram_out(prg_ram_out),
    .ppu_reg_cs_n(ppu_reg_cs_n), .ppu_reg_addr(ppu_reg_addr), .ppu_we(ppu_we),
    .ppu_data_out(ppu_data_out), .ppu_data_in(ppu_data_in),
    .kb_code(kb_code), .kb_valid(kb_valid), .kb_make(kb_make), .pad_state(pad_state));
  cpu_bus_mapper #(.NUM_PADS(1), .PRG_ROM_KB(16), .PRG_RAM_EN(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .addr(addr), .we(we), .re(re), .data_in(data_in), .data_out(data_out2),
    .cpu_ram_addr(cpu_ram_addr2), .cpu_ram_we(cpu_ram_we2), .cpu_ram_out(cpu_ram_out),
    .prg_rom_addr(prg_rom_addr2), .prg_rom_out(prg_rom_out),
    .prg_ram_addr(prg_ram_addr2), .prg_ram_we(prg_ram_we2), .prg_ram_out(prg_ram_out),
    .ppu_reg_cs_n(ppu_reg_cs_n2), .ppu_reg_addr(ppu_reg_addr2), .ppu_we(ppu_we2),
    .ppu_data_out(ppu_data_out2), .ppu_data_in(ppu_data_in),
    .kb_code(kb_code), .kb_valid(kb_valid), .kb_make(kb_make), .pad_state(pad_state2));
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", n, act, exp, $time);
    end
  endtask
  // Model: live pads, latched byte per pad and how many bits have been read out of it.
  logic [1:0][7:0] m_pad, m_lat;
  int m_cnt [2];
  logic m_strobe;
  function automatic int key_idx(input logic [7:0] c);
    case (c)
      8'h1C: return 7;  8'h1B: return 6;  8'h29: return 5;  8'h5A: return 4;
      8'h43: return 3;  8'h42: return 2;  8'h3B: return 1;  8'h4B: return 0;
      8'h70: return 15; 8'h71: return 14; 8'h59: return 13; 8'h12: return 12;
      8'h75: return 11; 8'h73: return 10; 8'h6B: return 9;  8'h74: return 8;
      default: return -1;
    endcase
  endfunction
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_strobe <= 1'b0;
      m_pad <= '0;
      m_lat <= '0;
      for (int p = 0; p < 2; p++) m_cnt[p] <= 0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (m_strobe) begin
          m_lat[p] <= m_pad[p];
          m_cnt[p] <= 0;
        end else if (re && addr == 16'(16'h4016 + p)) m_cnt[p] <= m_cnt[p] < 8 ? m_cnt[p] + 1 : 8;
      end
      if (we && addr == 16'h4016) m_strobe <= data_in[0];
      if (kb_valid && key_idx(kb_code) >= 0) m_pad[key_idx(kb_code) / 8][key_idx(kb_code) % 8] <= kb_make;
    end
  end
  function automatic logic mbit(input int p);
    if (m_strobe) return m_pad[p][7];
    return m_cnt[p] < 8 ? m_lat[p][7 - m_cnt[p]] : 1'b1;
  endfunction
  function automatic logic [7:0] exp_dout(input logic [15:0] a, input bit two, input bit ramen);
    if (a == 16'h4016) return {7'd0, mbit(0)};
    if (a == 16'h4017) return two ? {7'd0, mbit(1)} : 8'h00;
    if (a < 16'h2000) return 8'hA1;
    if (a < 16'h4000) return 8'hB2;
    if (a >= 16'h6000 && a < 16'h8000) return ramen ? 8'hC3 : 8'h00;
    if (a >= 16'h8000) return 8'hD4;
    return 8'h00;
  endfunction
  logic e_ram, e_ppu, e_pram, e_rom;
  assign e_ram  = addr < 16'h2000;
  assign e_ppu  = addr >= 16'h2000 && addr < 16'h4000;
  assign e_pram = addr >= 16'h6000 && addr < 16'h8000;
  assign e_rom  = addr >= 16'h8000;
  always @(negedge clk) if (go) begin
    chk("data_out", 32'(data_out), 32'(exp_dout(addr, 1, 1)));
    chk("data_out2", 32'(data_out2), 32'(exp_dout(addr, 0, 0)));
    chk("cpu_ram_we", 32'(cpu_ram_we), 32'(we && e_ram));
    chk("ppu_reg_cs_n", 32'(ppu_reg_cs_n), 32'(!e_ppu));
    chk("ppu_we", 32'(ppu_we), 32'(we && e_ppu));
    chk("prg_ram_we", 32'(prg_ram_we), 32'(we && e_pram));
    chk("prg_ram_we2", 32'(prg_ram_we2), 32'(0));
    chk("pad_state", 32'(pad_state), 32'(m_pad));
    chk("pad_state2", 32'(pad_state2), 32'(m_pad[0]));
    if (e_ram) chk("cpu_ram_addr", 32'(cpu_ram_addr), 32'(addr % 2048));
    if (e_ppu) begin
      chk("ppu_reg_addr", 32'(ppu_reg_addr), 32'(addr % 8));
      chk("ppu_data_out", 32'(ppu_data_out), 32'(data_in));
    end
    if (e_pram) chk("prg_ram_addr", 32'(prg_ram_addr), 32'(addr % 8192));
    if (e_rom) begin
      chk("prg_rom_addr", 32'(prg_rom_addr), 32'(addr % 32768));
      chk("prg_rom_addr2", 32'(prg_rom_addr2), 32'(addr % 16384));
    end
  end
  logic [7:0] s_dout, s_rom, s_rom2_lo;
  logic [14:0] s_rom_full, s_rom2;
  logic [10:0] s_ram_addr;
  logic [2:0] s_ppu_addr;
  logic s_ram_we, s_cs_n;
  task automatic acc(input logic [15:0] a, input logic w, input logic r, input logic [7:0] d);
    addr = a; we = w; re = r; data_in = d;
    @(negedge clk);
    s_dout = data_out; s_rom_full = prg_rom_addr; s_rom2 = prg_rom_addr2;
    s_ram_addr = cpu_ram_addr; s_ppu_addr = ppu_reg_addr; s_ram_we = cpu_ram_we; s_cs_n = ppu_reg_cs_n;
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0; addr = 16'h5000;
  endtask
  task automatic key(input logic [7:0] c, input logic m);
    kb_code = c; kb_make = m; kb_valid = 1'b1;
    @(posedge clk); #1;
    kb_valid = 1'b0;
  endtask
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    logic [9:0] seq;
    seq = 10'b1000000111;
    #2 reset_n = 1'b0;
    go = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pad_state", 32'(pad_state), 32'h0);
    reset_n = 1'b1;
    acc(16'h4016, 0, 1, 8'h00);
    chk("reset_first_read", 32'(s_dout), 32'h0);
    acc(16'h0805, 1, 0, 8'h5A);
    chk("ram_we_0805", 32'(s_ram_we), 32'h1);
    chk("ram_addr_0805", 32'(s_ram_addr), 32'h005);
    acc(16'h3FFA, 1, 0, 8'h33);
    chk("ppu_cs_3FFA", 32'(s_cs_n), 32'h0);
    chk("ppu_addr_3FFA", 32'(s_ppu_addr), 32'h2);
    acc(16'hC123, 0, 1, 8'h00);
    chk("rom32_C123", 32'(s_rom_full), 32'h4123);
    chk("rom16_C123", 32'(s_rom2), 32'h0123);
    chk("rom_data", 32'(s_dout), 32'hD4);
    acc(16'h1234, 0, 1, 8'h00);
    acc(16'h6000, 1, 1, 8'h77);
    chk("pram_data", 32'(s_dout), 32'hC3);
    acc(16'h5000, 1, 0, 8'hFF);
    acc(16'h4017, 1, 0, 8'h01);
    chk("we4017_ram_we", 32'(s_ram_we), 32'h0);
    key(8'h1C, 1);
    key(8'h4B, 1);
    key(8'h99, 1);
    acc(16'h4016, 1, 0, 8'h01);
    acc(16'h4016, 1, 0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      acc(16'h4016, 0, 1, 8'h00);
      chk("seq_read", 32'(s_dout), 32'(seq[9 - i]));
    end
    acc(16'h4016, 1, 0, 8'h01);
    addr = 16'h4016; re = 1'b1;
    for (int i = 0; i < 4; i++) begin
      kb_code = 8'h1C; kb_make = 1'(i % 2); kb_valid = 1'b1;
      @(posedge clk); #1;
      kb_valid = 1'b0;
      @(negedge clk);
      chk("live_a", 32'(data_out), 32'(i % 2));
    end
    @(posedge clk); #1;
    re = 1'b0; addr = 16'h5000;
    key(8'h1C, 0);
    key(8'h4B, 0);
    key(8'h1B, 1);
    key(8'h42, 1);
    key(8'h12, 1);
    acc(16'h4016, 1, 0, 8'h00);
    chk("pads_44_10", 32'(pad_state), 32'h1044);
    for (int i = 0; i < 4; i++) begin
      acc(16'h4016, 0, 1, 8'h00);
      if (i == 1) chk("pad0_b", 32'(s_dout), 32'h1);
    end
    for (int i = 0; i < 4; i++) acc(16'h4017, 0, 1, 8'h00);
    chk("pad1_start", 32'(s_dout), 32'h1);
    acc(16'h4016, 0, 1, 8'h00);
    chk("pad0_up", 32'(s_dout), 32'h0);
    acc(16'h4016, 0, 1, 8'h00);
    chk("pad0_down", 32'(s_dout), 32'h1);
    acc(16'h4016, 1, 0, 8'h01);
    acc(16'h4016, 1, 0, 8'h00);
    for (int i = 0; i < 3; i++) acc(16'h4016, 0, 1, 8'h00);
    chk("pre_reset_read", 32'(s_dout), 32'h0);
    reset_n = 1'b0;
    #1;
    chk("async_reset_pad", 32'(pad_state), 32'h0);
    chk("async_reset_pad2", 32'(pad_state2), 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    acc(16'h4016, 0, 1, 8'h00);
    chk("post_reset_read", 32'(s_dout), 32'h0);
    acc(16'h4016, 0, 1, 8'h00);
    chk("post_reset_read2", 32'(s_dout), 32'h0);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
